// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: ALU opcodes, the zero
// register index, ID/EX stage state encoding and the forwarding-hit test.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HELD  = 2'd2
  } stage_state_t;

  // A later-stage producer supplies idx only if it writes a non-zero register.
  function automatic logic fwd_hit(input logic we, input logic [4:0] dest,
                                   input logic [4:0] idx);
    return we && (dest != REG_ZERO) && (dest == idx);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass selector: EX/MEM result beats MEM/WB result, which beats
// the value captured from the register file.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [4:0]    idx_i,
  input  logic [DW-1:0] stored_i,
  input  logic          mem_reg_write_i,
  input  logic [4:0]    mem_dest_i,
  input  logic [DW-1:0] mem_result_i,
  input  logic          wb_reg_write_i,
  input  logic [4:0]    wb_dest_i,
  input  logic [DW-1:0] wb_result_i,
  output logic [DW-1:0] val_o
);

  // Priority select of the youngest matching producer.
  always_comb begin
    val_o = stored_i;
    if (fwd_hit(mem_reg_write_i, mem_dest_i, idx_i)) begin
      val_o = mem_result_i;
    end else if (fwd_hit(wb_reg_write_i, wb_dest_i, idx_i)) begin
      val_o = wb_result_i;
    end else begin
      val_o = stored_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: valid/ready handshake, load-use
// bubble insertion, same-cycle operand forwarding and a saturating stall counter.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [DW-1:0]   id_rs_data,
  input  logic [DW-1:0]   id_rt_data,
  input  logic [DW-1:0]   id_imm,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_dest,
  input  logic [3:0]      id_alu_ctrl,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_dest,
  input  logic [DW-1:0]   mem_result,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_dest,
  input  logic [DW-1:0]   wb_result,
  output logic            ex_valid,
  output logic [DW-1:0]   ex_input1,
  output logic [DW-1:0]   ex_input2,
  output logic [3:0]      ex_alu_ctrl,
  output logic [DW-1:0]   ex_store_data,
  output logic [4:0]      ex_dest,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [CNTW-1:0] stall_count
);

  stage_state_t  state_q, state_d;
  logic [DW-1:0] rs_val_q, rs_val_d;
  logic [DW-1:0] rt_val_q, rt_val_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [4:0]    rs_idx_q, rs_idx_d;
  logic [4:0]    rt_idx_q, rt_idx_d;
  logic [4:0]    dest_q, dest_d;
  logic [3:0]    alu_ctrl_q, alu_ctrl_d;
  logic          alu_src_q, alu_src_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [CNTW-1:0] stall_q, stall_d;

  logic          adv_s;
  logic          hz_s;
  logic [DW-1:0] rs_fwd_s;
  logic [DW-1:0] rt_fwd_s;

  fwd_mux #(.DW(DW)) u_fwd_rs (
    .idx_i           (rs_idx_q),
    .stored_i        (rs_val_q),
    .mem_reg_write_i (mem_reg_write),
    .mem_dest_i      (mem_dest),
    .mem_result_i    (mem_result),
    .wb_reg_write_i  (wb_reg_write),
    .wb_dest_i       (wb_dest),
    .wb_result_i     (wb_result),
    .val_o           (rs_fwd_s)
  );

  fwd_mux #(.DW(DW)) u_fwd_rt (
    .idx_i           (rt_idx_q),
    .stored_i        (rt_val_q),
    .mem_reg_write_i (mem_reg_write),
    .mem_dest_i      (mem_dest),
    .mem_result_i    (mem_result),
    .wb_reg_write_i  (wb_reg_write),
    .wb_dest_i       (wb_dest),
    .wb_result_i     (wb_result),
    .val_o           (rt_fwd_s)
  );

  assign ex_valid      = (state_q != ST_EMPTY);
  assign adv_s         = !ex_valid || ex_ready;
  assign hz_s          = ex_valid && mem_read_q && (dest_q != REG_ZERO) &&
                         ((dest_q == id_rs) || (dest_q == id_rt)) && id_valid;
  assign id_ready      = flush ? 1'b1 : (adv_s && !hz_s);

  assign ex_input1     = rs_fwd_s;
  assign ex_input2     = alu_src_q ? imm_q : rt_fwd_s;
  assign ex_store_data = rt_fwd_s;
  assign ex_alu_ctrl   = alu_ctrl_q;
  assign ex_dest       = dest_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign stall_count   = stall_q;

  // Next-state selection: flush > hold > bubble > load > drain.
  always_comb begin
    state_d     = state_q;
    rs_val_d    = rs_val_q;
    rt_val_d    = rt_val_q;
    imm_d       = imm_q;
    rs_idx_d    = rs_idx_q;
    rt_idx_d    = rt_idx_q;
    dest_d      = dest_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_src_d   = alu_src_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    stall_d     = stall_q;
    if (flush || (adv_s && (hz_s || !id_valid))) begin
      state_d     = ST_EMPTY;
      dest_d      = REG_ZERO;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      if (!flush && hz_s && (stall_q != {CNTW{1'b1}})) begin
        stall_d = stall_q + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        stall_d = stall_q;
      end
    end else if (!adv_s) begin
      // A producer retiring while EX stalls must not be lost.
      state_d  = ST_HELD;
      rs_val_d = rs_fwd_s;
      rt_val_d = rt_fwd_s;
    end else begin
      state_d     = ST_FULL;
      rs_val_d    = id_rs_data;
      rt_val_d    = id_rt_data;
      imm_d       = id_imm;
      rs_idx_d    = id_rs;
      rt_idx_d    = id_rt;
      dest_d      = id_dest;
      alu_ctrl_d  = id_alu_ctrl;
      alu_src_d   = id_alu_src;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
    end
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      rs_val_q    <= {DW{1'b0}};
      rt_val_q    <= {DW{1'b0}};
      imm_q       <= {DW{1'b0}};
      rs_idx_q    <= REG_ZERO;
      rt_idx_q    <= REG_ZERO;
      dest_q      <= REG_ZERO;
      alu_ctrl_q  <= 4'b0000;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      stall_q     <= {CNTW{1'b0}};
    end else begin
      state_q     <= state_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      imm_q       <= imm_d;
      rs_idx_q    <= rs_idx_d;
      rt_idx_q    <= rt_idx_d;
      dest_q      <= dest_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      stall_q     <= stall_d;
    end
  end

endmodule
